// File: rtl/word_serializer.sv
// word_serializer: takes an IN_W-bit word over a valid/ready handshake and
// emits it as 1..N symbols of OUT_W bits, one per cycle, in LSB-first or
// MSB-first order. A new word can be accepted in the same cycle that the last
// symbol of the previous word is consumed, so consecutive words stream
// without a bubble.
module word_serializer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  localparam int N     = IN_W / OUT_W,
  localparam int LEN_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IN_W-1:0]  hold_q,  hold_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic             order_q, order_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [LEN_W-1:0] eff_len;
  logic [CNT_W-1:0] idx;
  logic             last_sym;
  logic             accept;
  logic             xfer;

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  assign last_sym  = (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));
  assign out_last  = out_valid && last_sym;
  assign in_ready  = !out_valid || (out_ready && last_sym);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  // Map a requested length of 0 or anything above N to a full word.
  always_comb begin
    eff_len = in_len;
    if (in_len == '0 || in_len > LEN_W'(N)) begin
      eff_len = LEN_W'(N);
    end
  end

  // Select the symbol position from the counter and the latched order.
  always_comb begin
    idx = cnt_q;
    if (order_q) begin
      idx = CNT_W'(N - 1) - cnt_q;
    end
  end

  // Present the selected symbol; forced to zero while nothing is held.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = hold_q[int'(idx)*OUT_W +: OUT_W];
    end
  end

  // Next-state logic: an accept (which, while sending, can only coincide with
  // the final transfer) reloads everything; otherwise a transfer advances.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    len_d   = len_q;
    order_d = order_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SEND;
      hold_d  = in_data;
      len_d   = eff_len;
      order_d = in_msb_first;
      cnt_d   = '0;
    end else if (xfer) begin
      if (last_sym) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      len_q   <= '0;
      order_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      len_q   <= len_d;
      order_q <= order_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (IN_W=32, OUT_W=8).
module tb_word_serializer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_len;
  logic        in_msb_first;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int n_assert;
  int n_fail;

  word_serializer #(.IN_W(32), .OUT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_len       (in_len),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current symbol mid-cycle, then move to just after the next edge.
  task automatic sym(input string tag, input logic [7:0] d, input logic l, input logic rdy);
    #2;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_busy"},  {31'd0, busy},      32'd1);
    chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
    chk({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
    chk({tag, "_inrdy"}, {31'd0, in_ready},  {31'd0, rdy});
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input string tag);
    #2;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"},  {24'd0, out_data},  32'd0);
    chk({tag, "_last"},  {31'd0, out_last},  32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_inrdy"}, {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
  endtask

  // Present a word and let the next edge accept it.
  task automatic offer(input string tag, input logic [31:0] d, input logic [2:0] len, input logic msb);
    in_valid     = 1'b1;
    in_data      = d;
    in_len       = len;
    in_msb_first = msb;
    #2;
    chk({tag, "_accept_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    in_len   = 3'd0;
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] bp_sym [8];
    logic       bp_rdy [8];
    logic       bp_last[8];
    logic       bp_ir  [8];

    n_assert     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_len       = '0;
    in_msb_first = 1'b0;
    out_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset release, idle for 5 cycles
    for (int i = 0; i < 5; i++) idle_chk("rst_idle");

    // LSB-first full word via in_len=0
    offer("lsb", 32'hAABBCCDD, 3'd0, 1'b0);
    sym("lsb0", 8'hDD, 1'b0, 1'b0);
    sym("lsb1", 8'hCC, 1'b0, 1'b0);
    sym("lsb2", 8'hBB, 1'b0, 1'b0);
    sym("lsb3", 8'hAA, 1'b1, 1'b1);
    idle_chk("lsb_after");

    // MSB-first, 2 symbols
    offer("msb2", 32'h11223344, 3'd2, 1'b1);
    sym("msb2_0", 8'h11, 1'b0, 1'b0);
    sym("msb2_1", 8'h22, 1'b1, 1'b1);
    idle_chk("msb2_after");

    // MSB-first, oversized length means full word
    offer("msb7", 32'h11223344, 3'd7, 1'b1);
    sym("msb7_0", 8'h11, 1'b0, 1'b0);
    sym("msb7_1", 8'h22, 1'b0, 1'b0);
    sym("msb7_2", 8'h33, 1'b0, 1'b0);
    sym("msb7_3", 8'h44, 1'b1, 1'b1);
    idle_chk("msb7_after");

    // Back-to-back words with in_valid held
    offer("b2b_a", 32'h03020100, 3'd0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h07060504;
    in_len   = 3'd0;
    sym("b2b_00", 8'h00, 1'b0, 1'b0);
    sym("b2b_01", 8'h01, 1'b0, 1'b0);
    sym("b2b_02", 8'h02, 1'b0, 1'b0);
    sym("b2b_03", 8'h03, 1'b1, 1'b1);
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    sym("b2b_04", 8'h04, 1'b0, 1'b0);
    sym("b2b_05", 8'h05, 1'b0, 1'b0);
    sym("b2b_06", 8'h06, 1'b0, 1'b0);
    sym("b2b_07", 8'h07, 1'b1, 1'b1);
    idle_chk("b2b_after");

    // Back-pressure with out_ready pattern 1,0,0,1
    bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bp_sym  = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h44, 8'h44};
    bp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_ir   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    offer("bp", 32'h44332211, 3'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      out_ready = bp_rdy[i];
      sym("bp", bp_sym[i], bp_last[i], bp_ir[i]);
    end
    out_ready = 1'b1;
    idle_chk("bp_after");

    // Reset mid-word
    offer("rst_word", 32'hDEADBEEF, 3'd0, 1'b0);
    sym("rst_w0", 8'hEF, 1'b0, 1'b0);
    sym("rst_w1", 8'hBE, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_data",  {24'd0, out_data},  32'd0);
    chk("rst_async_last",  {31'd0, out_last},  32'd0);
    chk("rst_async_busy",  {31'd0, busy},      32'd0);
    chk("rst_async_inrdy", {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_chk("rst_post0");
    idle_chk("rst_post1");
    offer("one", 32'h00000055, 3'd1, 1'b0);
    sym("one0", 8'h55, 1'b1, 1'b1);
    idle_chk("one_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parametrised word-to-symbol serializer with valid/ready handshakes on both sides. Accepts an IN_W-bit word and emits it as up to IN_W/OUT_W symbols of OUT_W bits, one per cycle, in LSB-first or MSB-first order, with a per-word symbol count. Sits between the processor's 32-bit datapath and byte-wide peripherals such as the UART TX and the display driver. It supersedes the fixed, free-running 32-to-8 converter, which had no flow control.

## Interface
- IN_W, 32, input word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output symbol width.
- N, IN_W/OUT_W (derived, localparam), symbols per word.
- LEN_W, $clog2(N)+1 (derived, localparam), width of in_len.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_data, in_len and in_msb_first are valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  IN_W  word to serialize.
- in_len  in  LEN_W  number of symbols to emit, 1..N. A value of 0 or any value >N means N.
- in_msb_first  in  1  0: symbol k = in_data[k*OUT_W +: OUT_W], k ascending from 0. 1: symbols from index N-1 descending.
- out_valid  out  1  out_data holds a valid symbol.
- out_ready  in  1  downstream consumes the symbol this cycle.
- out_data  out  OUT_W  current symbol; 0 whenever out_valid=0.
- out_last  out  1  current symbol is the final one of its word; 0 whenever out_valid=0.
- busy  out  1  a word is held; equals out_valid.

## Operation
- State: holding register (IN_W), effective length len_q, order bit, symbol counter cnt (0..N-1), valid flag. Two states:
  - IDLE: valid=0.
  - SEND: valid=1.
- Accept condition: accept = in_valid && in_ready.
- in_ready (combinational) = !out_valid || (out_ready && out_last). This permits back-to-back words with no bubble.
- On accept:
  - Latch in_data, the effective length and in_msb_first.
  - Set cnt=0 and enter SEND. This applies whether the block was IDLE or was completing the last symbol of the previous word.
- In SEND, the symbol index is cnt when order=0 and N-1-cnt when order=1.
  - out_data = hold[index*OUT_W +: OUT_W].
  - out_last = (cnt == len_q-1).
- Symbol transfer = out_valid && out_ready.
  - Not last: cnt increments.
  - Last without a new accept: return to IDLE, cnt=0.
  - Last with a simultaneous accept: the new word is loaded and the block stays in SEND.
- Back-pressure: while out_valid && !out_ready, out_data, out_last, cnt and the holding register are all stable.
- Input changes while the block is busy are ignored; only accepted words are sampled.
- Reset (any time, including mid-word): the held word is discarded, with no partial output afterwards.
  - Reset values: out_valid=0, out_data=0, out_last=0, busy=0, cnt=0, hold=0.
  - in_ready evaluates to 1.

## Timing
- Latency: a word accepted at rising edge t gives its first symbol on out_data during cycle t+1 (the cycle after edge t).
- Throughput: one symbol per clock while out_ready=1. A word of L symbols occupies exactly L cycles with no idle cycles between consecutive words.
- No combinational path from in_data to out_data.
- in_ready depends combinationally on out_ready.

## Test plan
- Reset release, no input: out_valid=0, out_data=0, out_last=0, in_ready=1 for 5 cycles.
- LSB-first, 0xAABBCCDD, in_len=0, out_ready=1: symbols DD, CC, BB, AA on 4 consecutive cycles, out_last only with AA. Then idle, in_ready=1.
- MSB-first, 0x11223344, in_len=2: symbols 11, 22, out_last on 22. Repeat with in_len=7, which must give 4 symbols 11, 22, 33, 44.
- Back-to-back: 0x03020100 then 0x07060504 presented with in_valid held, out_ready=1. Required response:
  - 8 contiguous symbols 00 through 07.
  - in_ready=1 in the cycle of symbol 03.
  - in_ready=0 during symbols 00-02.
- Back-pressure: out_ready toggles in a 1,0,0,1 pattern. Each symbol must be held unchanged while out_ready=0, with no symbol lost or duplicated.
- Reset asserted after 2 symbols of 0xDEADBEEF: outputs are 0 within the same cycle. After release, a new word 0x00000055 with in_len=1 gives the single symbol 55 with out_last=1.
